// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word and the RAM status encoding
// seen by every cache and arbiter on the memory bus.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data has priority,
// with a starvation counter that forces an instruction grant.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGRANT = 2'd1;
    localparam logic [1:0] DGRANT = 2'd2;

    localparam int unsigned        STARVE_W   = 2;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [STARVE_W-1:0] starve;
    ramstate_t           ram_st;
    word_t               load_word;
    logic                access;
    logic                d_req;
    logic                i_done;
    logic                d_done;
    logic                i_starved;

    assign ram_st    = ramstate_t'(ramstate);
    assign access    = (ram_st == ACCESS);
    assign d_req     = dREN | dWEN;
    assign i_done    = (state == IGRANT) && iREN && access;
    assign d_done    = (state == DGRANT) && d_req && access;
    assign i_starved = iREN && (starve == STARVE_LIM);

    // Read data is broadcast; the wait lines tell each cache when it is valid.
    assign load_word = ramload;
    assign iload     = load_word;
    assign dload     = load_word;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counts data completions that happened while an instruction fetch waited.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve <= '0;
        end else if (i_done) begin
            starve <= '0;
        end else if (d_done && iREN && (starve != STARVE_LIM)) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_req && !i_starved) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                if (!iREN || access) begin
                    next_state = IDLE;
                end
            end
            DGRANT: begin
                if (!d_req || access) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode; a write request masks a simultaneous read strobe.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !i_done;
            end
            DGRANT: begin
                ramREN   = dREN && !dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !d_done;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 3, the consecutive data completions tolerated while an instruction request waits.
REQ-002 The block SHALL have port CLK, input, 1, system clock.
REQ-003 The block SHALL have port nRST, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port iREN, input, 1, icache read request.
REQ-005 The block SHALL have port iaddr, input, 32, icache word address.
REQ-006 The block SHALL have port dREN, input, 1, dcache read request.
REQ-007 The block SHALL have port dWEN, input, 1, dcache write request.
REQ-008 The block SHALL have port daddr, input, 32, dcache word address.
REQ-009 The block SHALL have port dstore, input, 32, dcache write data.
REQ-010 The block SHALL have port iwait, output, 1, icache stall (0 = iload valid this cycle).
REQ-011 The block SHALL have port dwait, output, 1, dcache stall (0 = access complete this cycle).
REQ-012 The block SHALL have port iload, output, 32, instruction word returned.
REQ-013 The block SHALL have port dload, output, 32, data word returned.
REQ-014 The block SHALL have ports ramREN and ramWEN, output, 1 each, RAM strobes.
REQ-015 The block SHALL have ports ramaddr and ramstore, output, 32 each, RAM address and write data.
REQ-016 The block SHALL have port ramload, input, 32, RAM read data.
REQ-017 The block SHALL have port ramstate, input, 2, RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-018 The FSM SHALL have three states: IDLE, IGRANT, DGRANT.
REQ-019 In IDLE, if (dREN|dWEN) and not (iREN and starve==STARVE_MAX), the next state SHALL be DGRANT.
REQ-020 Otherwise in IDLE, if iREN, the next state SHALL be IGRANT; otherwise IDLE.
REQ-021 In IDLE, all RAM strobes SHALL be 0 and iwait=dwait=1.
REQ-022 In DGRANT: ramaddr=daddr, ramREN=dREN, ramWEN=dWEN, ramstore=dstore; if dREN and dWEN are both 1, ramWEN SHALL win and ramREN SHALL be 0.
REQ-023 In IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-024 The owner's wait SHALL be 0 only in the cycle the state grants it and ramstate==ACCESS; the non-owner's wait SHALL stay 1.
REQ-025 On ACCESS the FSM SHALL return to IDLE next cycle; back-to-back accesses therefore have a minimum spacing of one IDLE cycle.
REQ-026 BUSY, FREE and ERROR SHALL hold the grant and keep the owner's wait at 1; ERROR is not a completion.
REQ-027 If the owner deasserts its request while granted, the FSM SHALL return to IDLE next cycle, with strobes 0 in that cycle.
REQ-028 There SHALL be no preemption: a new request from the other cache during a grant SHALL only be considered in IDLE.
REQ-029 iload and dload SHALL both equal ramload combinationally at all times.
REQ-030 Starve counter (2 bits): +1 on each DGRANT completion while iREN=1; saturates at STARVE_MAX; cleared on IGRANT completion.

Reset
REQ-031 On nRST=0, state SHALL be IDLE and starve SHALL be 0, asynchronously.
REQ-032 During reset all RAM strobes, ramaddr and ramstore SHALL be 0 and iwait=dwait=1.
REQ-033 Reset asserted mid-grant SHALL abandon the access with no completion reported.

Structure
REQ-034 word_t and the ramstate enum SHALL come from shared cpu_types_pkg, and the FSM state enum SHALL be local to the module.
REQ-035 The block SHALL have no sub-module: one state register, one counter, and combinational output decode.

Verification
REQ-036 iREN=1, iaddr=0x40, RAM ACCESS on 2nd grant cycle -> ramaddr=0x40, ramREN=1; iwait=0 for exactly one cycle; iload=ramload.
REQ-037 iREN and dWEN rise in the same cycle, daddr=0x80, dstore=0xDEADBEEF -> DGRANT first with ramWEN=1 and ramstore=0xDEADBEEF; IGRANT follows after the IDLE cycle.
REQ-038 dREN held high for 4 accesses while iREN=1 -> after 3 data completions IGRANT is taken; starve returns to 0.
REQ-039 ramstate=ERROR for 5 cycles during DGRANT, then ACCESS -> dwait stays 1 throughout ERROR, then goes 0 for one cycle.
REQ-040 nRST pulsed low mid-IGRANT -> state returns to IDLE, strobes 0, iwait=1, and no completion is reported.
REQ-041 dREN=dWEN=1, dREN then dropped mid-grant -> ramREN=0 at all times (write wins); dropping dREN and dWEN returns the FSM to IDLE the next cycle.
